// File: rtl/serpar_pkg.sv
// Shared constants for the parametrised serial-to-parallel receiver:
// FSM state encoding and the default idle/comma symbol.
package serpar_pkg;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ALIGN  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  localparam logic [7:0] COMMA_DEF = 8'hBC;

endpackage

// File: rtl/serpar_comma_det.sv
// Serial shift register plus comma comparator; win is the most recent
// DATA_W bits including the bit currently on data_out.
module serpar_comma_det
  import serpar_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter logic [DATA_W-1:0] COMMA  = DATA_W'(COMMA_DEF)
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_out,
  output logic [DATA_W-1:0] win,
  output logic              comma_hit
);

  logic [DATA_W-2:0] sr;

  assign win       = {sr, data_out};
  assign comma_hit = (win == COMMA);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else begin
      sr <= win[DATA_W-2:0];
    end
  end

endmodule

// File: rtl/serial_paralelo_param.sv
// Serial-to-parallel receiver: comma search, word alignment and locked word output.
// Optional macro SERPAR_RESYNC_EN: leave ACTIVE after repeated off-boundary commas.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_SEARCH | sliding-window comma search on every bit (encoding 3 too)
//   ST_ALIGN  | checking for commas at each word boundary until LOCK_CNT
//   ST_ACTIVE | locked; one word emitted per boundary
module serial_paralelo_param
  import serpar_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] COMMA    = DATA_W'(COMMA_DEF),
  parameter int                LOCK_CNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              data_out,
  output logic [DATA_W-1:0] data_rx,
  output logic              valid_rx,
  output logic              word_stb,
  output logic              active,
  output logic [1:0]        state_o
);

  localparam int              BC_W     = $clog2(DATA_W);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_W - 1);
  localparam logic [3:0]      LOCK_V   = 4'(LOCK_CNT);

  logic [DATA_W-1:0] win;
  logic              comma_hit;
  logic [1:0]        state;
  logic [BC_W-1:0]   bit_cnt;
  logic [3:0]        comma_cnt;
  logic              at_bnd;
  logic              drop;

  serpar_comma_det #(
    .DATA_W (DATA_W),
    .COMMA  (COMMA)
  ) u_comma_det (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_out  (data_out),
    .win       (win),
    .comma_hit (comma_hit)
  );

  assign at_bnd  = (bit_cnt == BIT_LAST);
  assign state_o = state;

`ifdef SERPAR_RESYNC_EN
  logic [3:0] miss_cnt;
  logic       off_hit;

  // A boundary counts as a miss when a comma was seen off-boundary in the same word.
  assign drop = (state == ST_ACTIVE) && at_bnd && off_hit && (miss_cnt + 4'd1 == LOCK_V);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      miss_cnt <= '0;
      off_hit  <= 1'b0;
    end else if (state != ST_ACTIVE || drop) begin
      miss_cnt <= '0;
      off_hit  <= 1'b0;
    end else if (at_bnd) begin
      miss_cnt <= off_hit ? miss_cnt + 4'd1 : 4'd0;
      off_hit  <= 1'b0;
    end else if (comma_hit) begin
      off_hit <= 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state     <= ST_SEARCH;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      data_rx   <= '0;
      valid_rx  <= 1'b0;
      word_stb  <= 1'b0;
      active    <= 1'b0;
    end else begin
      bit_cnt  <= at_bnd ? '0 : bit_cnt + 1'b1;
      word_stb <= 1'b0;
      case (state)
        ST_ALIGN: begin
          if (at_bnd) begin
            if (comma_hit) begin
              if (comma_cnt != LOCK_V) comma_cnt <= comma_cnt + 4'd1;
              if (comma_cnt + 4'd1 == LOCK_V) begin
                state  <= ST_ACTIVE;
                active <= 1'b1;
              end
            end else begin
              state     <= ST_SEARCH;
              comma_cnt <= '0;
            end
          end
        end
        ST_ACTIVE: begin
          if (drop) begin
            state     <= ST_SEARCH;
            active    <= 1'b0;
            valid_rx  <= 1'b0;
            comma_cnt <= '0;
          end else if (at_bnd) begin
            data_rx  <= win;
            valid_rx <= !comma_hit;
            word_stb <= 1'b1;
          end
        end
        default: begin
          state <= ST_SEARCH;
          if (comma_hit) begin
            bit_cnt   <= '0;
            comma_cnt <= 4'd1;
            if (LOCK_CNT == 1) begin
              state  <= ST_ACTIVE;
              active <= 1'b1;
            end else begin
              state <= ST_ALIGN;
            end
          end
        end
      endcase
    end
  end

endmodule
